// File: rtl/rb_fifo_ctr.sv
// rb_fifo_ctr: parametrised synchronous ring-buffer FIFO with first-word
// fall-through output, simultaneous push/pop, occupancy and almost-full /
// almost-empty thresholds. DEPTH need not be a power of two.
// Optional macro RBF_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module rb_fifo_ctr #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              push,
    input  logic              pop,
    output logic [DATA_W-1:0] dataOut,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              almostFull,
    output logic              almostEmpty
`ifdef RBF_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_LVL);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic              push_acc;
    logic              pop_acc;

    // Explicit wrap so non-power-of-two depths step DEPTH-1 -> 0.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + AW'(1);
    endfunction

    // A pop on an empty FIFO is dropped; a push on a full FIFO is only
    // accepted when a pop frees the head slot in the same cycle.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop);

    // Status is decoded from the occupancy counter, not pointer equality.
    assign count       = cnt;
    assign full        = (cnt == FULL_CNT);
    assign empty       = (cnt == '0);
    assign almostFull  = (cnt >= AF_CNT);
    assign almostEmpty = (cnt <= AE_CNT);
    assign dataOut     = mem[tail];

    // Pointer and occupancy update; reset discards all queued words.
    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) head <= next_idx(head);
            if (pop_acc)  tail <= next_idx(tail);
            if (push_acc && !pop_acc)      cnt <= cnt + CW'(1);
            else if (pop_acc && !push_acc) cnt <= cnt - CW'(1);
        end
    end

    // Storage write; contents are never cleared, only the pointers are.
    always_ff @(posedge clock) begin
        if (push_acc && !reset) mem[head] <= dataIn;
    end

`ifdef RBF_ERR_FLAGS_EN
    // Sticky illegal-access flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop)  overflow  <= 1'b1;
            if (pop && empty && !push) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rb_fifo_ctr.sv
// Testbench for rb_fifo_ctr: directed scenarios plus randomized traffic
// against a queue-based reference model. DEPTH=4 and DEPTH=3 instances.
module tb_rb_fifo_ctr;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] din4, dout4, din3, dout3;
    logic       push4, pop4, push3, pop3;
    logic       full4, empty4, af4, ae4;
    logic       full3, empty3, af3, ae3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;
`ifdef RBF_ERR_FLAGS_EN
    logic       ovf4, unf4, ovf3, unf3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues plus sticky flag bits.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    logic       m_ovf4, m_unf4;

    rb_fifo_ctr #(.DATA_W(8), .DEPTH(4)) u4 (
        .clock(clock), .reset(reset), .dataIn(din4), .push(push4), .pop(pop4),
        .dataOut(dout4), .full(full4), .empty(empty4), .count(cnt4),
        .almostFull(af4), .almostEmpty(ae4)
`ifdef RBF_ERR_FLAGS_EN
        , .overflow(ovf4), .underflow(unf4)
`endif
    );

    rb_fifo_ctr #(.DATA_W(8), .DEPTH(3)) u3 (
        .clock(clock), .reset(reset), .dataIn(din3), .push(push3), .pop(pop3),
        .dataOut(dout3), .full(full3), .empty(empty3), .count(cnt3),
        .almostFull(af3), .almostEmpty(ae3)
`ifdef RBF_ERR_FLAGS_EN
        , .overflow(ovf3), .underflow(unf3)
`endif
    );

    task automatic do_reset(input logic ps, input logic pp);
        reset = 1'b1; push4 = ps; pop4 = pp; din4 = 8'hEE;
        push3 = ps; pop3 = pp; din3 = 8'hEE;
        @(posedge clock); #1;
        reset = 1'b0; push4 = 1'b0; pop4 = 1'b0; push3 = 1'b0; pop3 = 1'b0;
        q4.delete(); q3.delete(); m_ovf4 = 1'b0; m_unf4 = 1'b0;
    endtask

    task automatic step4(input logic ps, input logic pp, input logic [7:0] d);
        bit pa, wa;
        int sz;
        sz = q4.size();
        push4 = ps; pop4 = pp; din4 = d;
        pa = pp && (sz > 0);
        wa = ps && ((sz < 4) || pp);
        if (ps && sz == 4 && !pp) m_ovf4 = 1'b1;
        if (pp && sz == 0 && !ps) m_unf4 = 1'b1;
        if (pa) void'(q4.pop_front());
        if (wa) q4.push_back(d);
        @(posedge clock); #1;
        push4 = 1'b0; pop4 = 1'b0;
    endtask

    task automatic step3(input logic ps, input logic pp, input logic [7:0] d);
        bit pa, wa;
        int sz;
        sz = q3.size();
        push3 = ps; pop3 = pp; din3 = d;
        pa = pp && (sz > 0);
        wa = ps && ((sz < 3) || pp);
        if (pa) void'(q3.pop_front());
        if (wa) q3.push_back(d);
        @(posedge clock); #1;
        push3 = 1'b0; pop3 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt4); end
        n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty4); end
        n_checks++; if (full4 !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full4); end
        n_checks++; if (af4 !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", af4); end
        n_checks++; if (ae4 !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", ae4); end
        n_checks++; if (cnt3 !== 2'd0 || empty3 !== 1'b1) begin n_fail++; $display("FAIL reset_d3: got count %0d empty %b expected 0 1", cnt3, empty3); end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (ovf4 !== 1'b0 || unf4 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", ovf4, unf4); end
`endif
    endtask

    task automatic test_fill();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, 1'b0, words[i]);
            n_checks++; if (cnt4 !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", cnt4, i + 1); end
            n_checks++; if (full4 !== (i == 3)) begin n_fail++; $display("FAIL fill_full: got %b expected %b", full4, (i == 3)); end
            n_checks++; if (af4 !== (i >= 2)) begin n_fail++; $display("FAIL fill_afull: got %b expected %b", af4, (i >= 2)); end
            n_checks++; if (dout4 !== 8'h11) begin n_fail++; $display("FAIL fill_dout: got %h expected 11", dout4); end
        end
    endtask

    task automatic test_overflow();
        step4(1'b1, 1'b0, 8'h55);
        n_checks++; if (cnt4 !== 3'd4 || full4 !== 1'b1) begin n_fail++; $display("FAIL ovf_state: got count %0d full %b expected 4 1", cnt4, full4); end
        n_checks++; if (dout4 !== 8'h11) begin n_fail++; $display("FAIL ovf_dout: got %h expected 11", dout4); end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf4); end
        step4(1'b0, 1'b0, 8'h00);
        n_checks++; if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf4); end
`endif
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp [4];
        exp = '{8'h22, 8'h33, 8'h44, 8'h55};
        step4(1'b1, 1'b1, 8'h55);
        n_checks++; if (cnt4 !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d expected 4", cnt4); end
        n_checks++; if (dout4 !== 8'h22) begin n_fail++; $display("FAIL fpp_dout: got %h expected 22", dout4); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dout4 !== exp[i]) begin n_fail++; $display("FAIL fpp_drain: got %h expected %h", dout4, exp[i]); end
            step4(1'b0, 1'b1, 8'h00);
        end
        n_checks++; if (empty4 !== 1'b1 || cnt4 !== 3'd0) begin n_fail++; $display("FAIL fpp_empty: got empty %b count %0d expected 1 0", empty4, cnt4); end
    endtask

    task automatic test_empty_pushpop();
        step4(1'b1, 1'b1, 8'hA5);
        n_checks++; if (cnt4 !== 3'd1) begin n_fail++; $display("FAIL epp_count: got %0d expected 1", cnt4); end
        n_checks++; if (dout4 !== 8'hA5) begin n_fail++; $display("FAIL epp_dout: got %h expected a5", dout4); end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (unf4 !== 1'b0) begin n_fail++; $display("FAIL epp_unf: got %b expected 0", unf4); end
`endif
        step4(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_underflow();
        step4(1'b0, 1'b1, 8'h00);
        n_checks++; if (cnt4 !== 3'd0 || empty4 !== 1'b1) begin n_fail++; $display("FAIL unf_state: got count %0d empty %b expected 0 1", cnt4, empty4); end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (unf4 !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b expected 1", unf4); end
`endif
    endtask

    task automatic test_wrap3();
        step3(1'b1, 1'b0, 8'h40);
        for (int i = 1; i <= 10; i++) begin
            n_checks++; if (dout3 !== 8'(8'h40 + i - 1)) begin n_fail++; $display("FAIL wrap_pre: got %h expected %h", dout3, 8'(8'h40 + i - 1)); end
            step3(1'b1, 1'b1, 8'(8'h40 + i));
            n_checks++; if (cnt3 !== 2'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", cnt3); end
            n_checks++; if (dout3 !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL wrap_dout: got %h expected %h", dout3, 8'(8'h40 + i)); end
        end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (ovf3 !== 1'b0 || unf3 !== 1'b0) begin n_fail++; $display("FAIL wrap_flags: got %b%b expected 00", ovf3, unf3); end
`endif
        step3(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset_midop();
        step4(1'b1, 1'b0, 8'h01);
        step4(1'b1, 1'b0, 8'h02);
        step4(1'b1, 1'b0, 8'h03);
        n_checks++; if (cnt4 !== 3'd3) begin n_fail++; $display("FAIL rmid_pre: got %0d expected 3", cnt4); end
        do_reset(1'b1, 1'b0);
        n_checks++; if (cnt4 !== 3'd0 || empty4 !== 1'b1 || ae4 !== 1'b1) begin n_fail++; $display("FAIL rmid_state: got count %0d empty %b aempty %b expected 0 1 1", cnt4, empty4, ae4); end
`ifdef RBF_ERR_FLAGS_EN
        n_checks++; if (ovf4 !== 1'b0 || unf4 !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got %b%b expected 00", ovf4, unf4); end
`endif
        step4(1'b1, 1'b0, 8'h77);
        step4(1'b1, 1'b0, 8'h88);
        n_checks++; if (dout4 !== 8'h77 || cnt4 !== 3'd2) begin n_fail++; $display("FAIL rmid_post: got dout %h count %0d expected 77 2", dout4, cnt4); end
        step4(1'b0, 1'b1, 8'h00);
        n_checks++; if (dout4 !== 8'h88) begin n_fail++; $display("FAIL rmid_order: got %h expected 88", dout4); end
        step4(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random();
        int sz;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0)
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                step4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            sz = q4.size();
            n_checks++; if (cnt4 !== 3'(sz)) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", cnt4, sz); end
            n_checks++; if (full4 !== (sz == 4) || empty4 !== (sz == 0)) begin n_fail++; $display("FAIL rnd_fullempty: got %b%b expected %b%b", full4, empty4, (sz == 4), (sz == 0)); end
            n_checks++; if (af4 !== (sz >= 3) || ae4 !== (sz <= 1)) begin n_fail++; $display("FAIL rnd_almost: got %b%b expected %b%b", af4, ae4, (sz >= 3), (sz <= 1)); end
            if (sz > 0) begin
                n_checks++; if (dout4 !== q4[0]) begin n_fail++; $display("FAIL rnd_dout: got %h expected %h", dout4, q4[0]); end
            end
`ifdef RBF_ERR_FLAGS_EN
            n_checks++; if (ovf4 !== m_ovf4 || unf4 !== m_unf4) begin n_fail++; $display("FAIL rnd_flags: got %b%b expected %b%b", ovf4, unf4, m_ovf4, m_unf4); end
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        push4 = 1'b0; pop4 = 1'b0; din4 = 8'h00;
        push3 = 1'b0; pop3 = 1'b0; din3 = 8'h00;
        m_ovf4 = 1'b0; m_unf4 = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_underflow();
        test_wrap3();
        do_reset(1'b0, 1'b0);
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
